// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed multiply / divide unit for the execute stage.
//
// One operation at a time. MUL runs a shift-add loop over the multiplier
// bits, DIV runs a restoring shift-subtract loop. Both work on operand
// magnitudes, and the sign is applied in the FINISH cycle.
//
// Ports
//   clk          clock; all state changes happen on its rising edge
//   rst          synchronous active-high reset
//   start        request from the execute stage
//   alu_control  function select (MUL or DIV; other codes are ignored)
//   op_a, op_b   signed operands (op_a is the multiplicand / dividend)
//   result       low product word or quotient
//   result_r0    high product word or remainder
//   busy         operation in progress (RUN or FINISH)
//   done         one-cycle pulse; the results are valid in this cycle
//   div_by_zero  asserted with done when a DIV had op_b == 0
//   stall        pipeline stall request (combinational)
//
// Build option
//   MULDIV_ZERO_FASTPATH_EN  when defined, a MUL with a zero operand skips
//                            RUN and finishes in one cycle with a zero result.
//
// state  | meaning
// IDLE   | waiting for an accepted MUL/DIV request
// RUN    | one shift-add / shift-subtract iteration per cycle
// FINISH | sign correction, done pulse, results committed

module muldiv_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ALU_CONTROL_WIDTH = 4,
    parameter logic [ALU_CONTROL_WIDTH-1:0] MUL = ALU_CONTROL_WIDTH'(4'b0001),
    parameter logic [ALU_CONTROL_WIDTH-1:0] DIV = ALU_CONTROL_WIDTH'(4'b0010)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ALU_CONTROL_WIDTH-1:0] alu_control,
    input  logic [DATA_WIDTH-1:0]        op_a,
    input  logic [DATA_WIDTH-1:0]        op_b,
    output logic [DATA_WIDTH-1:0]        result,
    output logic [DATA_WIDTH-1:0]        result_r0,
    output logic                         busy,
    output logic                         done,
    output logic                         div_by_zero,
    output logic                         stall
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t state, state_next;

    logic            is_div, neg_q, neg_r, dz, zero_fast;
    logic [W-1:0]    hi, lo, b_mag;
    logic [W-1:0]    result_q, result_r0_q;
    logic [CW-1:0]   count;

    logic            valid_op, accept, skip_dz, skip_mul;
    logic [W-1:0]    a_abs, b_abs;
    logic [W:0]      mul_sum, div_shift, div_trial;
    logic [2*W-1:0]  prod, prod_s;
    logic [W-1:0]    fin_result, fin_r0;

    assign valid_op = (alu_control == MUL) || (alu_control == DIV);
    assign accept   = (state == IDLE) && start && valid_op;
    assign skip_dz  = (alu_control == DIV) && (op_b == '0);

`ifdef MULDIV_ZERO_FASTPATH_EN
    assign skip_mul = (alu_control == MUL) && ((op_a == '0) || (op_b == '0));
`else
    assign skip_mul = 1'b0;
`endif

    assign a_abs = op_a[W-1] ? -op_a : op_a;
    assign b_abs = op_b[W-1] ? -op_b : op_b;

    // MUL: hi:lo holds {partial product, remaining multiplier bits}.
    // DIV: hi is the partial remainder, lo shifts dividend bits out and
    // quotient bits in. The remainder stays below b_mag, so W+1 bits is
    // enough for the trial subtraction and its sign bit.
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
    assign div_shift = {hi, lo[W-1]};
    assign div_trial = div_shift - {1'b0, b_mag};

    assign prod   = {hi, lo};
    assign prod_s = neg_q ? -prod : prod;

    always_comb begin
        fin_result = result_q;
        fin_r0     = result_r0_q;
        if (dz) begin
            fin_result = result_q;
            fin_r0     = result_r0_q;
        end else if (zero_fast) begin
            fin_result = '0;
            fin_r0     = '0;
        end else if (is_div) begin
            fin_result = neg_q ? -lo : lo;
            fin_r0     = neg_r ? -hi : hi;
        end else begin
            fin_result = prod_s[W-1:0];
            fin_r0     = prod_s[2*W-1:W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (skip_dz || skip_mul) ? FINISH : RUN;
            RUN:     if (count == CW'(W - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            zero_fast   <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            b_mag       <= '0;
            count       <= '0;
            result_q    <= '0;
            result_r0_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div    <= (alu_control == DIV);
                        neg_q     <= op_a[W-1] ^ op_b[W-1];
                        neg_r     <= op_a[W-1];
                        dz        <= skip_dz;
                        zero_fast <= skip_mul;
                        hi        <= '0;
                        lo        <= a_abs;
                        b_mag     <= b_abs;
                        count     <= '0;
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (is_div) begin
                        if (!div_trial[W]) begin
                            hi <= div_trial[W-1:0];
                            lo <= {lo[W-2:0], 1'b1};
                        end else begin
                            hi <= div_shift[W-1:0];
                            lo <= {lo[W-2:0], 1'b0};
                        end
                    end else begin
                        {hi, lo} <= {mul_sum, lo[W-1:1]};
                    end
                end
                FINISH: begin
                    result_q    <= fin_result;
                    result_r0_q <= fin_r0;
                end
                default: ;
            endcase
        end
    end

    // During FINISH the corrected values are visible together with done;
    // afterwards the committed copies hold until the next operation.
    assign result      = (state == FINISH) ? fin_result : result_q;
    assign result_r0   = (state == FINISH) ? fin_r0     : result_r0_q;
    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);
    assign div_by_zero = (state == FINISH) && dz;
    assign stall       = (state == RUN) || accept;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases followed by random MUL/DIV
// operations, compared against plain integer arithmetic.
module tb_muldiv_unit;

    localparam int W = 16;
    localparam logic [3:0] C_MUL = 4'b0001;
    localparam logic [3:0] C_DIV = 4'b0010;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [3:0]    alu_control;
    logic [W-1:0]  op_a, op_b;
    logic [W-1:0]  result, result_r0;
    logic          busy, done, div_by_zero, stall;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_res = '0;
    logic [W-1:0] exp_r0  = '0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
        .op_a(op_a), .op_b(op_b), .result(result), .result_r0(result_r0),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: signed integer arithmetic; updates exp_res/exp_r0 unless div by zero.
    task automatic model(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic dz);
        int sa, sb, p;
        sa  = $signed(a);
        sb  = $signed(b);
        dz  = 1'b0;
        lat = W + 1;
        if (ctl == C_MUL) begin
            p = sa * sb;
            exp_res = p[15:0];
            exp_r0  = p[31:16];
`ifdef MULDIV_ZERO_FASTPATH_EN
            if (sa == 0 || sb == 0) lat = 1;
`endif
        end else if (sb == 0) begin
            dz  = 1'b1;
            lat = 1;
        end else begin
            p = sa / sb;
            exp_res = p[15:0];
            p = sa % sb;
            exp_r0 = p[15:0];
        end
    endtask

    task automatic run_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        int   lat, cyc;
        logic dz;
        bit   seen;
        model(ctl, a, b, lat, dz);
        @(negedge clk);
        start = 1'b1; alu_control = ctl; op_a = a; op_b = b;
        #1 chk({tag, " stall_req"}, stall, 1);
        @(negedge clk);
        cyc  = 1;
        seen = 1'b0;
        start = 1'b0;
        while (cyc <= 40 && !seen) begin
            if (cyc == 1) chk({tag, " stall_c1"}, stall, (lat > 1));
            if (done) seen = 1'b1;
            else begin
                // requests while busy must be ignored
                start = (cyc >= 2 && cyc <= 5);
                alu_control = C_MUL;
                op_a = W'($urandom);
                op_b = W'($urandom);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk({tag, " done_seen"}, seen, 1);
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " result_r0"}, result_r0, exp_r0);
        chk({tag, " div_by_zero"}, div_by_zero, dz);
        chk({tag, " stall_fin"}, stall, 0);
        chk({tag, " busy_fin"}, busy, 1);
        @(negedge clk);
        chk({tag, " busy_after"}, busy, 0);
        chk({tag, " done_after"}, done, 0);
        chk({tag, " hold_result"}, result, exp_res);
        chk({tag, " hold_r0"}, result_r0, exp_r0);
    endtask

    initial begin
        int done_cnt;
        logic [3:0] ctl;
        logic [W-1:0] a, b;

        rst = 1'b1; start = 1'b0; alu_control = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst result", result, 0);
        chk("rst result_r0", result_r0, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst dz", div_by_zero, 0);
        chk("rst stall", stall, 0);
        rst = 1'b0;

        run_op(C_MUL, 16'd300, 16'hFFF9, "mul_300_m7");
        run_op(C_DIV, 16'hFFEF, 16'd5, "div_m17_5");
        run_op(C_DIV, 16'd100, 16'd0, "div_by_zero");
        run_op(C_DIV, 16'h8000, 16'hFFFF, "div_minneg_m1");
        run_op(C_MUL, 16'd0, 16'd9, "mul_0_9");
        run_op(C_MUL, 16'd7, 16'd0, "mul_7_0");
        run_op(C_MUL, 16'h8000, 16'h8000, "mul_minneg_sq");
        run_op(C_DIV, 16'd7, 16'h8000, "div_small_big");

        // unsupported function code is ignored
        @(negedge clk);
        start = 1'b1; alu_control = 4'b1111; op_a = 16'd3; op_b = 16'd4;
        #1 chk("bad_code stall", stall, 0);
        done_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        start = 1'b0;
        chk("bad_code activity", done_cnt, 0);
        chk("bad_code result", result, exp_res);

        // abort a MUL with reset, then an unsupported request
        @(negedge clk);
        start = 1'b1; alu_control = C_MUL; op_a = 16'd123; op_b = 16'd45;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            if (done) done_cnt++;
            if (c == 5) rst = 1'b1;
            if (c == 6) rst = 1'b0;
            if (c == 8) begin start = 1'b1; alu_control = 4'b1111; end
            @(negedge clk);
        end
        exp_res = '0; exp_r0 = '0;
        chk("abort done_count", done_cnt, 0);
        chk("abort busy", busy, 0);
        chk("abort result", result, 0);
        chk("abort result_r0", result_r0, 0);
        chk("abort dz", div_by_zero, 0);
        chk("abort stall", stall, 0);
        start = 1'b0;

        for (int i = 0; i < 40; i++) begin
            ctl = ($urandom_range(0, 1) == 0) ? C_MUL : C_DIV;
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = 16'h8000;
                2: b = 16'hFFFF;
                3: b = W'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(ctl, a, b, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
